// File: rtl/task_stream_receiver.sv
// Receive side of the credit-based task injection stream: FIFO-buffered flit forwarding plus packet framing.
// Optional header target check is built when TASK_RX_ADDR_CHECK_EN is defined.
module task_stream_receiver #(
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int SIZE_W       = 16,
    parameter int N_PE_X       = 2,
    parameter int N_PE_Y       = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic                 eoa_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic [15:0]          pkt_cnt_o,
    output logic                 eoa_o,
    output logic                 size_err_o,
    output logic                 addr_err_o
);

    localparam int AW = $clog2(BUFFER_DEPTH);

    if (FLIT_SIZE != 32 || BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0 ||
        SIZE_W < 1 || SIZE_W >= FLIT_SIZE ||
        N_PE_X < 1 || N_PE_X > 256 || N_PE_Y < 1 || N_PE_Y > 256) begin : g_bad_cfg
        $error("task_stream_receiver: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_SIZE    = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    logic [FLIT_SIZE-1:0] r_mem [BUFFER_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [FLIT_SIZE-1:0] r_last;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SIZE_W-1:0]    r_remaining;
    logic [SIZE_W-1:0]    w_remaining_nxt;
    logic [SIZE_W-1:0]    w_size_field;
    logic                 w_pkt_done;
    logic [15:0]          r_pkt_cnt;
    logic                 r_eoa;
    logic                 r_size_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Full/empty come only from the registered count, so a same-cycle pop never frees credit early.
    assign w_full   = (r_count == (AW + 1)'(BUFFER_DEPTH));
    assign w_empty  = (r_count == '0);
    assign credit_o = !w_full;
    assign tx_o     = !w_empty;
    assign w_push   = rx_i && credit_o;
    assign w_pop    = tx_o && credit_i;

    // r_last keeps the most recently popped flit so data_o holds steady while the FIFO is empty.
    assign data_o   = w_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_size_field = data_i[SIZE_W-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_HEADER;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_pkt_done      = 1'b0;
        if (w_push) begin
            case (r_state)
                S_HEADER: w_state_nxt = S_SIZE;
                S_SIZE: begin
                    w_remaining_nxt = w_size_field;
                    if (w_size_field == '0) begin
                        w_state_nxt = S_HEADER;
                        w_pkt_done  = 1'b1;
                    end else begin
                        w_state_nxt = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    w_remaining_nxt = r_remaining - SIZE_W'(1);
                    if (r_remaining == SIZE_W'(1)) begin
                        w_state_nxt = S_HEADER;
                        w_pkt_done  = 1'b1;
                    end
                end
                default: w_state_nxt = S_HEADER;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pkt_cnt  <= '0;
            r_eoa      <= 1'b0;
            r_size_err <= 1'b0;
        end else begin
            if (w_pkt_done) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_push && r_state == S_SIZE && (|data_i[FLIT_SIZE-1:SIZE_W])) begin
                r_size_err <= 1'b1;
            end
            // End of application only once framing is idle and every buffered flit has left.
            if (eoa_i && r_state == S_HEADER && w_empty && !rx_i) begin
                r_eoa <= 1'b1;
            end
        end
    end

    assign pkt_cnt_o  = r_pkt_cnt;
    assign eoa_o      = r_eoa;
    assign size_err_o = r_size_err;

`ifdef TASK_RX_ADDR_CHECK_EN
    logic r_addr_err;
    logic w_addr_bad;

    assign w_addr_bad = (int'(data_i[15:8]) >= N_PE_X) || (int'(data_i[7:0]) >= N_PE_Y);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr_err <= 1'b0;
        end else if (w_push && r_state == S_HEADER && w_addr_bad) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err_o = r_addr_err;
`else
    assign addr_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_task_stream_receiver.sv
// Directed bench for task_stream_receiver: framing, backpressure, error flags, end-of-application, reset.
module tb_task_stream_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        credit_out;
    logic [31:0] din;
    logic        eoa_in;
    logic        tx;
    logic        credit_in;
    logic [31:0] dout;
    logic [15:0] pkt_cnt;
    logic        eoa_out;
    logic        size_err;
    logic        addr_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] out_q[$];

    task_stream_receiver #(
        .FLIT_SIZE(32), .BUFFER_DEPTH(8), .SIZE_W(16), .N_PE_X(2), .N_PE_Y(2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_i       (rx),
        .credit_o   (credit_out),
        .data_i     (din),
        .eoa_i      (eoa_in),
        .tx_o       (tx),
        .credit_i   (credit_in),
        .data_o     (dout),
        .pkt_cnt_o  (pkt_cnt),
        .eoa_o      (eoa_out),
        .size_err_o (size_err),
        .addr_err_o (addr_err)
    );

    always #5 clk = ~clk;

    // Record every flit that leaves the block (sampled half a cycle before the popping edge).
    always @(negedge clk) begin
        if (rst_n && tx && credit_in) out_q.push_back(dout);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; rx = 1'b0; din = '0; eoa_in = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_credit"},   32'(credit_out), 32'd1);
        chk({tag, "_tx"},       32'(tx),         32'd0);
        chk({tag, "_data"},     dout,            32'd0);
        chk({tag, "_pkt"},      32'(pkt_cnt),    32'd0);
        chk({tag, "_eoa"},      32'(eoa_out),    32'd0);
        chk({tag, "_size_err"}, 32'(size_err),   32'd0);
        chk({tag, "_addr_err"}, 32'(addr_err),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_q.delete();
    endtask

    // Offer one flit and hold it until accepted; returns just after the accepting edge.
    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        rx = 1'b1; din = d;
        @(negedge clk);
        while (!credit_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!credit_out) chk("push_timeout", 32'(credit_out), 32'd1);
        @(posedge clk); #1;
        rx = 1'b0;
    endtask

    task automatic wait_out(input int cnt);
        int n;
        n = 0;
        while (out_q.size() < cnt && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        return (i < out_q.size()) ? out_q[i] : 32'hDEAD_BEEF;
    endfunction

    logic [31:0] basic_pkt [5] = '{32'h0101, 32'd3, 32'hA, 32'hB, 32'hC};

    initial begin
        rst_n = 1'b0; rx = 1'b0; din = '0; eoa_in = 1'b0; credit_in = 1'b0;

        // Basic packet: each flit appears on data_o the cycle after it is accepted.
        do_reset("rst0");
        credit_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx = 1'b1; din = basic_pkt[i];
            @(negedge clk);
            chk($sformatf("basic_credit%0d", i), 32'(credit_out), 32'd1);
            if (i > 0) begin
                chk($sformatf("basic_data%0d", i - 1), dout, basic_pkt[i - 1]);
                chk($sformatf("basic_tx%0d", i - 1), 32'(tx), 32'd1);
            end
            @(posedge clk); #1;
        end
        rx = 1'b0;
        @(negedge clk);
        chk("basic_data4", dout, 32'hC);
        chk("basic_pkt", 32'(pkt_cnt), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("basic_empty_tx", 32'(tx), 32'd0);
        chk("basic_empty_hold", dout, 32'hC);

        // Zero-size packets back to back, then a 1-flit packet proves framing returned to header.
        do_reset("rst1");
        credit_in = 1'b1;
        push(32'h0); push(32'h0); push(32'h0); push(32'h0);
        wait_out(4);
        chk("zero_pkt", 32'(pkt_cnt), 32'd2);
        chk("zero_nout", 32'(out_q.size()), 32'd4);
        push(32'h0); push(32'd1);
        chk("zero_mid_pkt", 32'(pkt_cnt), 32'd2);
        push(32'h55);
        chk("zero_after_pkt", 32'(pkt_cnt), 32'd3);

        // Backpressure: 8 accepts fill the FIFO, credit only returns the cycle after a pop.
        do_reset("rst2");
        credit_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx = 1'b1; din = 32'h100 + 32'(i);
            @(negedge clk);
            chk($sformatf("bp_credit%0d", i), 32'(credit_out), 32'd1);
            @(posedge clk); #1;
        end
        rx = 1'b1; din = 32'h108;
        @(negedge clk);
        chk("bp_full", 32'(credit_out), 32'd0);
        chk("bp_head", dout, 32'h100);
        @(posedge clk); #1;
        credit_in = 1'b1;
        @(negedge clk);
        chk("bp_full_pop", 32'(credit_out), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_credit_back", 32'(credit_out), 32'd1);
        @(posedge clk); #1;
        push(32'h109);
        wait_out(10);
        chk("bp_nout", 32'(out_q.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("bp_out%0d", i), q_at(i), 32'h100 + 32'(i));

        // Size error: upper bits flagged, packet framed as 2 payload flits.
        do_reset("rst3");
        credit_in = 1'b1;
        push(32'h0101);
        chk("sz_before", 32'(size_err), 32'd0);
        push(32'h0001_0002);
        chk("sz_flag", 32'(size_err), 32'd1);
        push(32'hD1);
        chk("sz_pkt_mid", 32'(pkt_cnt), 32'd0);
        push(32'hD2);
        chk("sz_pkt_done", 32'(pkt_cnt), 32'd1);
        push(32'h0); push(32'h0);
        chk("sz_next_pkt", 32'(pkt_cnt), 32'd2);
        wait_out(6);
        chk("sz_fwd_unchanged", q_at(1), 32'h0001_0002);

        // Header target check.
        do_reset("rst4");
        credit_in = 1'b1;
        push(32'h0101); push(32'h0);
        chk("addr_ok", 32'(addr_err), 32'd0);
        push(32'h0300); push(32'h0);
`ifdef TASK_RX_ADDR_CHECK_EN
        chk("addr_bad", 32'(addr_err), 32'd1);
`else
        chk("addr_bad", 32'(addr_err), 32'd0);
`endif
        chk("addr_pkt", 32'(pkt_cnt), 32'd2);

        // EOA: not while mid-packet, not while flits are buffered; set one cycle after draining.
        do_reset("rst5");
        credit_in = 1'b1;
        push(32'h0101); push(32'd3); push(32'hA);
        eoa_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("eoa_mid_pkt", 32'(eoa_out), 32'd0);
        @(posedge clk); #1;
        credit_in = 1'b0;
        push(32'hB); push(32'hC);
        @(negedge clk);
        chk("eoa_buffered0", 32'(eoa_out), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("eoa_buffered1", 32'(eoa_out), 32'd0);
        credit_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("eoa_drained_tx", 32'(tx), 32'd0);
        chk("eoa_drain_cycle", 32'(eoa_out), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("eoa_set", 32'(eoa_out), 32'd1);
        eoa_in = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("eoa_sticky", 32'(eoa_out), 32'd1);
        chk("eoa_pkt", 32'(pkt_cnt), 32'd1);

        // Reset in the middle of a packet with flits buffered and flags set.
        @(posedge clk); #1;
        credit_in = 1'b0;
        push(32'h0101); push(32'h0001_0005); push(32'hA);
        @(negedge clk);
        chk("mid_tx", 32'(tx), 32'd1);
        chk("mid_size_err", 32'(size_err), 32'd1);
        do_reset("rst_mid");
        credit_in = 1'b1;
        push(32'h0); push(32'h0);
        chk("mid_after_pkt", 32'(pkt_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
